hdmi_capture_ctrl: RTL and testbench

Frame-level scheduler for the `hdmi_to_blocks` converter. It watches the HDMI sync and valid stream and drives the converter's `en` input so capture starts and stops only on frame boundaries. It implements frame decimation (capture 1 frame, skip `cfg_skip` frames) and drops whole frames when the downstream encoder reports busy. It also checks each captured frame's geometry against `X_RES`/`Y_RES` and keeps frame and drop statistics.

---
 rtl/hdmi_ctrl_pkg.sv | 29 ++
 rtl/hdmi_capture_ctrl_geom_check.sv | 62 ++++++
 rtl/hdmi_capture_ctrl.sv | 126 ++++++++++++
 tb/tb_hdmi_capture_ctrl.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hdmi_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : hdmi_ctrl_pkg
// Description : Shared types and width helpers for the HDMI capture controller.
// Revision    : 1.0 - initial release
// ============================================================================
package hdmi_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SYNC = 2'd1,
        ST_RUN  = 2'd2,
        ST_SKIP = 2'd3
    } ctrl_state_t;

    // Widths for the default 2160x1200, 2 pixels/clock geometry.
    localparam int BEAT_W = $clog2(2160/2 + 1);
    localparam int LINE_W = $clog2(1200 + 1);

    function automatic int beat_width(input int x_res, input int n);
        return $clog2(x_res/n + 1);
    endfunction

    function automatic int line_width(input int y_res);
        return $clog2(y_res + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/hdmi_capture_ctrl_geom_check.sv
`default_nettype none
// ============================================================================
// Module      : hdmi_geom_check
// Description : Counts beats per line and lines per frame, flags mismatches.
// Revision    : 1.0 - initial release
// ============================================================================
module hdmi_geom_check
    import hdmi_ctrl_pkg::*;
#(
    parameter int N     = 2,
    parameter int X_RES = 2160,
    parameter int Y_RES = 1200
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic chk_en,
    input  logic valid,
    input  logic fe,
    output logic err
);

    localparam int C_BEAT_W = beat_width(X_RES, N);
    localparam int C_LINE_W = line_width(Y_RES);
    localparam logic [C_BEAT_W-1:0] C_BEAT_EXP = C_BEAT_W'(X_RES/N);
    localparam logic [C_LINE_W-1:0] C_LINE_EXP = C_LINE_W'(Y_RES);
    localparam logic [C_BEAT_W-1:0] C_BEAT_MAX = '1;
    localparam logic [C_LINE_W-1:0] C_LINE_MAX = '1;

    logic                r_valid_d;
    logic [C_BEAT_W-1:0] r_beat_cnt;
    logic [C_LINE_W-1:0] r_line_cnt;
    logic                w_line_end;

    assign w_line_end = r_valid_d & ~valid;

    // Combinational so the sticky flag upstream lands one cycle after valid falls.
    assign err = chk_en & ((w_line_end & (r_beat_cnt != C_BEAT_EXP)) |
                           (fe & (r_line_cnt != C_LINE_EXP)));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid_d  <= 1'b0;
            r_beat_cnt <= '0;
            r_line_cnt <= '0;
        end else begin
            r_valid_d <= valid;
            if (clr) begin
                r_beat_cnt <= '0;
                r_line_cnt <= '0;
            end else if (w_line_end) begin
                r_beat_cnt <= '0;
                if (r_line_cnt != C_LINE_MAX)
                    r_line_cnt <= r_line_cnt + C_LINE_W'(1);
            end else if (valid && (r_beat_cnt != C_BEAT_MAX)) begin
                r_beat_cnt <= r_beat_cnt + C_BEAT_W'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/hdmi_capture_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : hdmi_capture_ctrl
// Description : Frame-boundary capture scheduler with decimation and drop stats.
// Revision    : 1.0 - initial release
// ============================================================================
module hdmi_capture_ctrl
    import hdmi_ctrl_pkg::*;
#(
    parameter int N      = 2,
    parameter int X_RES  = 2160,
    parameter int Y_RES  = 1200,
    parameter int SKIP_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_start,
    input  logic              cfg_stop,
    input  logic [SKIP_W-1:0] cfg_skip,
    input  logic              enc_busy,
    input  logic              hdmi_v_sync,
    input  logic              hdmi_h_sync,
    input  logic              hdmi_data_valid,
    output logic              en,
    output logic              frame_done,
    output logic              err_geom,
    output logic [15:0]       frame_cnt,
    output logic [15:0]       drop_cnt,
    output logic [1:0]        state
);

    ctrl_state_t       r_state;
    logic              r_vs_d;
    logic              r_en;
    logic              r_frame_done;
    logic              r_err_geom;
    logic              r_stop_pend;
    logic [SKIP_W-1:0] r_skip_cnt;
    logic [15:0]       r_frame_cnt;
    logic [15:0]       r_drop_cnt;
    logic              w_fs;
    logic              w_fe;
    logic              w_geom_err;
    logic              w_unused_h_sync;

    assign w_fs            = r_vs_d & ~hdmi_v_sync;
    assign w_fe            = ~r_vs_d & hdmi_v_sync;
    assign w_unused_h_sync = hdmi_h_sync;

    hdmi_geom_check #(
        .N     (N),
        .X_RES (X_RES),
        .Y_RES (Y_RES)
    ) u_geom (
        .clk    (clk),
        .rst    (rst),
        .clr    (w_fs),
        .chk_en (r_state == ST_RUN),
        .valid  (hdmi_data_valid),
        .fe     (w_fe),
        .err    (w_geom_err)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_vs_d       <= 1'b0;
            r_en         <= 1'b0;
            r_frame_done <= 1'b0;
            r_err_geom   <= 1'b0;
            r_stop_pend  <= 1'b0;
            r_skip_cnt   <= '0;
            r_frame_cnt  <= '0;
            r_drop_cnt   <= '0;
        end else begin
            r_vs_d       <= hdmi_v_sync;
            r_frame_done <= (r_state == ST_RUN) && w_fe;
            if (w_geom_err)
                r_err_geom <= 1'b1;

            if (r_state == ST_IDLE) begin
                if (cfg_start && !cfg_stop) begin
                    r_state    <= ST_SYNC;
                    r_err_geom <= 1'b0;
                    r_skip_cnt <= '0;
                end
            end else begin
                // A stop arriving on the decision cycle only affects the next boundary.
                if (w_fs && r_stop_pend)
                    r_stop_pend <= 1'b0;
                else if (cfg_stop)
                    r_stop_pend <= 1'b1;

                if (w_fs) begin
                    if (r_stop_pend) begin
                        r_state <= ST_IDLE;
                        r_en    <= 1'b0;
                    end else if (r_skip_cnt != '0) begin
                        r_skip_cnt <= r_skip_cnt - SKIP_W'(1);
                        r_state    <= ST_SKIP;
                        r_en       <= 1'b0;
                    end else if (enc_busy) begin
                        if (r_drop_cnt != 16'hFFFF)
                            r_drop_cnt <= r_drop_cnt + 16'd1;
                        r_state <= ST_SKIP;
                        r_en    <= 1'b0;
                    end else begin
                        r_skip_cnt  <= cfg_skip;
                        r_frame_cnt <= r_frame_cnt + 16'd1;
                        r_state     <= ST_RUN;
                        r_en        <= 1'b1;
                    end
                end
            end
        end
    end

    assign en         = r_en;
    assign frame_done = r_frame_done;
    assign err_geom   = r_err_geom;
    assign frame_cnt  = r_frame_cnt;
    assign drop_cnt   = r_drop_cnt;
    assign state      = r_state;

endmodule
`default_nettype wire

// File: tb/tb_hdmi_capture_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_hdmi_capture_ctrl
// Description : Directed and randomized frame-level bench for hdmi_capture_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hdmi_capture_ctrl;

    localparam int N_PIX  = 2;
    localparam int XR     = 16;
    localparam int YR     = 16;
    localparam int SW     = 4;
    localparam int BEATS  = XR / N_PIX;
    localparam int S_IDLE = 0;
    localparam int S_SYNC = 1;
    localparam int S_RUN  = 2;
    localparam int S_SKIP = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          cfg_start;
    logic          cfg_stop;
    logic [SW-1:0] cfg_skip;
    logic          enc_busy;
    logic          hdmi_v_sync;
    logic          hdmi_h_sync;
    logic          hdmi_data_valid;
    logic          en;
    logic          frame_done;
    logic          err_geom;
    logic [15:0]   frame_cnt;
    logic [15:0]   drop_cnt;
    logic [1:0]    state;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model: frame-level view of what the controller should be doing.
    int m_state;
    bit m_en;
    bit m_err;
    bit m_stop;
    int m_skip;
    int m_frames;
    int m_drops;

    always #5 clk = ~clk;

    hdmi_capture_ctrl #(
        .N      (N_PIX),
        .X_RES  (XR),
        .Y_RES  (YR),
        .SKIP_W (SW)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .cfg_start       (cfg_start),
        .cfg_stop        (cfg_stop),
        .cfg_skip        (cfg_skip),
        .enc_busy        (enc_busy),
        .hdmi_v_sync     (hdmi_v_sync),
        .hdmi_h_sync     (hdmi_h_sync),
        .hdmi_data_valid (hdmi_data_valid),
        .en              (en),
        .frame_done      (frame_done),
        .err_geom        (err_geom),
        .frame_cnt       (frame_cnt),
        .drop_cnt        (drop_cnt),
        .state           (state)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag);
        chk({tag, ".en"},        32'(en),        32'(m_en));
        chk({tag, ".state"},     32'(state),     32'(m_state));
        chk({tag, ".frame_cnt"}, 32'(frame_cnt), 32'(m_frames & 16'hFFFF));
        chk({tag, ".drop_cnt"},  32'(drop_cnt),  32'(m_drops));
        chk({tag, ".err_geom"},  32'(err_geom),  32'(m_err));
    endtask

    task automatic model_reset();
        m_state = S_IDLE; m_en = 0; m_err = 0; m_stop = 0;
        m_skip = 0; m_frames = 0; m_drops = 0;
    endtask

    task automatic model_fs(input bit busy);
        if (m_state == S_IDLE) return;
        if (m_stop) begin
            m_state = S_IDLE;
            m_stop  = 0;
        end else if (m_skip != 0) begin
            m_skip--;
            m_state = S_SKIP;
        end else if (busy) begin
            if (m_drops < 65535) m_drops++;
            m_state = S_SKIP;
        end else begin
            m_state = S_RUN;
            m_skip  = int'(cfg_skip);
            m_frames++;
        end
        m_en = (m_state == S_RUN);
    endtask

    task automatic do_start(input bit with_stop);
        @(negedge clk);
        cfg_start = 1'b1;
        cfg_stop  = with_stop;
        if (m_state == S_IDLE) begin
            if (!with_stop) begin
                m_state = S_SYNC; m_err = 0; m_skip = 0;
            end
        end else if (with_stop) begin
            m_stop = 1;
        end
        @(negedge clk);
        cfg_start = 1'b0;
        cfg_stop  = 1'b0;
        chk_all("start");
    endtask

    // One frame: FS, back porch, nlines lines, front porch, FE; vsync left high.
    task automatic frame(input int nlines, input int bad_line, input int bad_beats,
                         input bit busy, input bit stop_fs, input int stop_line,
                         input int rst_line);
        bit was_idle;
        bit exp_done;
        @(negedge clk);
        hdmi_v_sync = 1'b0;
        enc_busy    = busy;
        cfg_stop    = stop_fs;
        was_idle    = (m_state == S_IDLE);
        model_fs(busy);
        if (stop_fs && !was_idle && m_state != S_IDLE) m_stop = 1;
        @(negedge clk);
        enc_busy = 1'b0;
        cfg_stop = 1'b0;
        chk_all("fs");
        repeat (3) @(negedge clk);
        for (int l = 0; l < nlines; l++) begin
            int nb;
            nb = (l == bad_line) ? bad_beats : BEATS;
            for (int b = 0; b < nb; b++) begin
                hdmi_data_valid = 1'b1;
                hdmi_h_sync     = 1'b0;
                if (l == rst_line && b == 3) begin
                    #2;
                    rst = 1'b1;
                    #1;
                    model_reset();
                    chk_all("async_rst");
                    @(negedge clk);
                    rst = 1'b0;
                end else begin
                    @(negedge clk);
                end
            end
            hdmi_data_valid = 1'b0;
            hdmi_h_sync     = 1'b1;
            if (m_state == S_RUN && nb != BEATS) m_err = 1;
            if (l == stop_line) begin
                cfg_stop = 1'b1;
                if (m_state != S_IDLE) m_stop = 1;
            end
            @(negedge clk);
            cfg_stop = 1'b0;
            chk("line.err_geom", 32'(err_geom), 32'(m_err));
            chk("line.en",       32'(en),       32'(m_en));
            repeat (2) @(negedge clk);
        end
        repeat (2) @(negedge clk);
        hdmi_v_sync = 1'b1;
        exp_done    = (m_state == S_RUN);
        if (m_state == S_RUN && nlines != YR) m_err = 1;
        @(negedge clk);
        chk("fe.frame_done", 32'(frame_done), 32'(exp_done));
        chk("fe.err_geom",   32'(err_geom),   32'(m_err));
        chk("fe.en",         32'(en),         32'(m_en));
        @(negedge clk);
        chk("fe.done_pulse", 32'(frame_done), 32'(0));
        repeat (2) @(negedge clk);
    endtask

    task automatic good_frame();
        frame(YR, -1, 0, 1'b0, 1'b0, -1, -1);
    endtask

    // Stop mid-frame, then one more frame to reach IDLE.
    task automatic stop_session();
        frame(YR, -1, 0, 1'b0, 1'b0, 2, -1);
        good_frame();
        chk("stop.state", 32'(state), 32'(S_IDLE));
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; cfg_start = 0; cfg_stop = 0; cfg_skip = '0; enc_busy = 0;
        hdmi_v_sync = 1'b1; hdmi_h_sync = 0; hdmi_data_valid = 0;
        model_reset();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk_all("reset");
        chk("reset.frame_done", 32'(frame_done), 32'(0));

        // Three good frames back to back, then stop.
        do_start(1'b0);
        repeat (3) good_frame();
        chk("s1.frame_cnt", 32'(frame_cnt), 32'(3));
        stop_session();

        // Decimation 1-in-3.
        cfg_skip = 4'd2;
        do_start(1'b0);
        repeat (6) good_frame();
        chk("s2.drop_cnt", 32'(drop_cnt), 32'(0));
        stop_session();

        // Busy encoder on the second boundary.
        cfg_skip = 4'd0;
        do_start(1'b0);
        good_frame();
        frame(YR, -1, 0, 1'b1, 1'b0, -1, -1);
        good_frame();
        chk("s3.drop_cnt", 32'(drop_cnt), 32'(m_drops));
        stop_session();

        // Short line sets the sticky error; only a new start clears it.
        do_start(1'b0);
        frame(YR, 3, 7, 1'b0, 1'b0, -1, -1);
        good_frame();
        stop_session();
        chk("s4.err_sticky", 32'(err_geom), 32'(1));
        do_start(1'b0);
        chk("s4.err_cleared", 32'(err_geom), 32'(0));
        stop_session();
        do_start(1'b1);

        // Frame with no active lines.
        do_start(1'b0);
        frame(0, -1, 0, 1'b0, 1'b0, -1, -1);
        stop_session();

        // Asynchronous reset mid-line, then no capture without a start.
        do_start(1'b0);
        good_frame();
        frame(YR, -1, 0, 1'b0, 1'b0, -1, 4);
        repeat (2) good_frame();

        // Randomized sessions.
        for (int s = 0; s < 5; s++) begin
            cfg_skip = SW'($urandom_range(0, 2));
            do_start(1'b0);
            for (int f = 0; f < 6; f++) begin
                int  bl;
                int  bb;
                bit  busy;
                bit  sfs;
                busy = ($urandom_range(0, 3) == 0);
                sfs  = ($urandom_range(0, 7) == 0);
                bl   = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, YR-1)) : -1;
                bb   = int'($urandom_range(1, 12));
                frame(YR, bl, bb, busy, sfs, -1, -1);
            end
            stop_session();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
